// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out frame capture block.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } sipo_state_e;

    localparam logic START_BIT = 1'b1;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial shift register; shift direction selects whether the first bit ends in the MSB or the LSB.
module sipo_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Shift state: cleared by reset, advances only on qualified bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (shift_en) begin
            if (MSB_FIRST) begin
                r_q <= {r_q[WIDTH-2:0], bit_in};
            end else begin
                r_q <= {bit_in, r_q[WIDTH-1:1]};
            end
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sipo_frame_capture.sv
// Start-bit framer: shifts WIDTH qualified bits and holds the word on a valid/ready port.
module sipo_frame_capture
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    if (WIDTH < 2) begin : g_width_check
        $error("sipo_frame_capture: WIDTH must be >= 2");
    end

    sipo_state_e      r_state;
    sipo_state_e      w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic             w_shift_en;
    logic             w_load;
    logic             w_overrun;
    logic             w_start;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next_word;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_busy;
    logic             r_overrun;
    logic             r_prev_hold;
    logic [WIDTH-1:0] r_prev_data;

    assign w_start = bit_en & (bit_in == START_BIT);

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .shift_en (w_shift_en),
        .bit_in   (bit_in),
        .q        (w_q)
    );

    // The captured word must include the bit being sampled on the final edge
    if (MSB_FIRST) begin : g_next_msb
        assign w_next_word = {w_q[WIDTH-2:0], bit_in};
    end else begin : g_next_lsb
        assign w_next_word = {bit_in, w_q[WIDTH-1:1]};
    end

    // Next-state, counter and strobe decode
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_en   = 1'b0;
        w_load       = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_next = SHIFT;
                    w_cnt_next   = '0;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SHIFT: begin
                if (bit_en) begin
                    w_shift_en = 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_load       = 1'b1;
                        w_state_next = HOLD;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_state_next = SHIFT;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    // A start bit coincident with acceptance begins the next frame immediately
                    if (w_start) begin
                        w_state_next = SHIFT;
                        w_cnt_next   = '0;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else if (w_start) begin
                    w_overrun = 1'b1;
                end else begin
                    w_state_next = HOLD;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_data    <= w_load ? w_next_word : r_data;
            r_valid   <= (w_state_next == HOLD);
            r_busy    <= (w_state_next != IDLE);
            r_overrun <= w_overrun;
        end
    end

    // Remember whether the word was held unaccepted, for the stability invariant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_hold <= 1'b0;
            r_prev_data <= '0;
        end else begin
            r_prev_hold <= r_valid & ~out_ready;
            r_prev_data <= r_data;
        end
    end

    // Non-temporal invariants of the framer
    always @(posedge clk) begin
        if (!rst) begin
            assert final (!r_valid || (r_state == HOLD))
                else $error("out_valid outside HOLD");
            assert final (r_busy == (r_state != IDLE))
                else $error("busy inconsistent with state");
            assert final ({{(32-CW){1'b0}}, r_cnt} < WIDTH)
                else $error("bit counter out of range");
            assert final (!r_prev_hold || (r_data == r_prev_data))
                else $error("out_data changed while held");
            assert final (!r_overrun || r_valid)
                else $error("overrun without held word");
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_sipo_frame_capture.sv
// Scoreboarded bench for sipo_frame_capture: MSB-first instance plus an LSB-first twin on the same stream.
module tb_sipo_frame_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_en;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       overrun;
    logic [7:0] out_data_lsb;
    logic       out_valid_lsb;
    logic       busy_lsb;
    logic       overrun_lsb;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    logic       mon_prev = 1'b0;

    always #5 clk = ~clk;

    sipo_frame_capture #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .overrun(overrun)
    );

    sipo_frame_capture #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en),
        .out_data(out_data_lsb), .out_valid(out_valid_lsb), .out_ready(out_ready),
        .busy(busy_lsb), .overrun(overrun_lsb)
    );

    // Every new out_valid pulse of the MSB-first instance consumes one expected word
    always @(negedge clk) begin
        if (out_valid === 1'b1 && mon_prev !== 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected_frame got=%h required=none", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard_word got=%h required=%h", out_data, mon_exp);
                end
            end
        end
        mon_prev = out_valid;
    end

    task automatic drive(input logic b, input logic en, input logic rdy);
        @(negedge clk);
        bit_in    = b;
        bit_en    = en;
        out_ready = rdy;
    endtask

    // Start bit then w[7]..w[0], with gap unqualified cycles before each data bit
    task automatic send_frame(input logic [7:0] w, input int gap, input logic rdy);
        exp_q.push_back(w);
        drive(1'b1, 1'b1, rdy);
        for (int i = 7; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) drive(1'($urandom_range(1, 0)), 1'b0, rdy);
            drive(w[i], 1'b1, rdy);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bit_in    = 1'($urandom_range(1, 0));
        bit_en    = 1'($urandom_range(1, 0));
        out_ready = 1'($urandom_range(1, 0));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (out_data !== 8'h00 || out_data_lsb !== 8'h00) begin
                errors++;
                $display("FAIL reset_data got=%h/%h required=00", out_data, out_data_lsb);
            end
            checks++;
            if ({out_valid, busy, overrun} !== 3'b000) begin
                errors++;
                $display("FAIL reset_flags got v/b/o=%b required=000", {out_valid, busy, overrun});
            end
            bit_in    = 1'($urandom_range(1, 0));
            bit_en    = 1'($urandom_range(1, 0));
            out_ready = 1'($urandom_range(1, 0));
        end
        rst    = 1'b0;
        bit_en = 1'b0;
    endtask

    task automatic test_basic();
        send_frame(8'hB4, 0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_early_valid got v/b=%b%b required=01", out_valid, busy);
        end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hB4) begin
            errors++;
            $display("FAIL basic_msb got v=%b d=%h required v=1 d=b4", out_valid, out_data);
        end
        checks++;
        if (out_valid_lsb !== 1'b1 || out_data_lsb !== 8'h2D) begin
            errors++;
            $display("FAIL basic_lsb got v=%b d=%h required v=1 d=2d", out_valid_lsb, out_data_lsb);
        end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_release got v/b=%b%b required=00", out_valid, busy);
        end
    endtask

    task automatic test_hold();
        send_frame(8'hB4, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, (i == 4));
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hB4) begin
                errors++;
                $display("FAIL hold_stable[%0d] got v=%b d=%h required v=1 d=b4", i, out_valid, out_data);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got v/b=%b%b required=00", out_valid, busy);
        end
    endtask

    task automatic test_overrun();
        send_frame(8'hB4, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre got v/o=%b%b required=10", out_valid, overrun);
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (overrun !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hB4) begin
            errors++;
            $display("FAIL overrun_pulse got o=%b v=%b d=%h required o=1 v=1 d=b4", overrun, out_valid, out_data);
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (overrun !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hB4) begin
            errors++;
            $display("FAIL overrun_width got o=%b v=%b d=%h required o=0 v=1 d=b4", overrun, out_valid, out_data);
        end
        send_frame(8'h3C, 0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            errors++;
            $display("FAIL back_to_back got v=%b d=%h required v=1 d=3c", out_valid, out_data);
        end
        drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_slow_enable();
        send_frame(8'hB4, 2, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL slow_early_valid got v=%b required=0", out_valid);
        end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hB4) begin
            errors++;
            $display("FAIL slow_word got v=%b d=%h required v=1 d=b4", out_valid, out_data);
        end
        drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        drive(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'($urandom_range(1, 0)), 1'b1, 1'b1);
        @(negedge clk);
        rst    = 1'b1;
        bit_en = 1'b1;
        bit_in = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        bit_en = 1'b0;
        checks++;
        if ({out_valid, busy, overrun} !== 3'b000 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_state got v/b/o=%b d=%h required 000 d=00", {out_valid, busy, overrun}, out_data);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'($urandom_range(1, 0)), 1'b1);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_idle[%0d] got v/b=%b%b required=00", i, out_valid, busy);
            end
        end
        send_frame(8'h3C, 0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
            errors++;
            $display("FAIL midreset_next got v=%b d=%h required v=1 d=3c", out_valid, out_data);
        end
        drive(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_overrun();
        test_slow_enable();
        test_reset_mid_frame();
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
